// File: rtl/mac_pkg.sv
// Shared types and helpers for the streaming MAC engine.
// Default widths come from the DATA_WIDTH / ACC_WIDTH macros when they are defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package mac_pkg;

    localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
    localparam int DEF_ACC_WIDTH  = `ACC_WIDTH;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int PROD_WIDTH     = 2 * DEF_DATA_WIDTH;
    // Widest accumulator the helper below can serve.
    localparam int SEXT_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

    // Sign-extends a product to SEXT_WIDTH; callers keep the low ACC_WIDTH bits.
    function automatic logic signed [SEXT_WIDTH-1:0] sext_prod(
        input logic signed [PROD_WIDTH-1:0] p
    );
        return SEXT_WIDTH'(p);
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Start/operand/result bundle of the MAC engine; slave = engine side, master = driver side.
// With MAC_BIAS_EN defined the bundle also carries bias_in.
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
    // high; valid never waits for ready, and data is held while valid is high and ready low.
    logic                         start;
    logic        [LEN_WIDTH-1:0]  cfg_len;
    logic                         busy;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_a;
    logic signed [DATA_WIDTH-1:0] in_b;
    logic                         out_valid;
    logic                         out_ready;
    logic        [ACC_WIDTH-1:0]  out_acc;
`ifdef MAC_BIAS_EN
    logic        [ACC_WIDTH-1:0]  bias_in;
`endif

    modport slave (
`ifdef MAC_BIAS_EN
        input  bias_in,
`endif
        input  start, cfg_len, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_acc
    );

    modport master (
`ifdef MAC_BIAS_EN
        output bias_in,
`endif
        output start, cfg_len, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_acc
    );
endinterface

// File: rtl/mac_mult.sv
// Combinational signed multiplier, kept separate so a pipelined/DSP variant can replace it.
module mac_mult #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic signed [2*DATA_WIDTH-1:0] prod
);
    assign prod = a * b;
endmodule

// File: rtl/mac_accumulator.sv
// Streaming signed dot-product engine; the sum wraps, clamping is left to the quantizer.
// MAC_BIAS_EN defined: the accumulator starts from bias_in instead of zero.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_accumulator_if.slave     bus,
    output mac_state_t           dbg_state
);

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_too_narrow
        $error("mac_accumulator: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end
    if (ACC_WIDTH > SEXT_WIDTH) begin : g_acc_too_wide
        $error("mac_accumulator: ACC_WIDTH exceeds SEXT_WIDTH");
    end
    if (DATA_WIDTH != DEF_DATA_WIDTH) begin : g_data_width_mismatch
        $error("mac_accumulator: DATA_WIDTH must match the package product width");
    end

    mac_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   out_acc_q, out_acc_d;
    logic [ACC_WIDTH-1:0]   init_val;
    logic signed [PROD_WIDTH-1:0] prod;

`ifdef MAC_BIAS_EN
    assign init_val = bus.bias_in;
`else
    assign init_val = '0;
`endif

    mac_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .prod (prod)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = init_val;
                    cnt_d   = bus.cfg_len;
                    state_d = (bus.cfg_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d = acc_q + ACC_WIDTH'(sext_prod(prod));
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A start arriving together with out_ready is dropped: we pass through IDLE first.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies decoded from the next state.
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        out_acc_d   = (state_d == DONE) ? acc_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a 32-bit and a 16-bit accumulator instance share one stimulus
// stream; expected results are queued by the driver and popped by a monitor.
module tb_mac_accumulator;
    import mac_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic               start     = 1'b0;
    logic [15:0]        cfg_len   = '0;
    logic               in_valid  = 1'b0;
    logic signed [7:0]  in_a      = '0;
    logic signed [7:0]  in_b      = '0;
    logic               out_ready = 1'b1;

    mac_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LEN_WIDTH(16)) bus ();
    mac_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(16)) bus16 ();

    assign bus.start       = start;
    assign bus.cfg_len     = cfg_len;
    assign bus.in_valid    = in_valid;
    assign bus.in_a        = in_a;
    assign bus.in_b        = in_b;
    assign bus.out_ready   = out_ready;
    assign bus16.start     = start;
    assign bus16.cfg_len   = cfg_len;
    assign bus16.in_valid  = in_valid;
    assign bus16.in_a      = in_a;
    assign bus16.in_b      = in_b;
    assign bus16.out_ready = out_ready;
`ifdef MAC_BIAS_EN
    logic [31:0] bias = '0;
    assign bus.bias_in   = bias;
    assign bus16.bias_in = bias[15:0];
`endif

    mac_state_t st32, st16;

    mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LEN_WIDTH(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (st32)
    );

    mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus16.slave),
        .dbg_state (st16)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp16_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    task automatic push_exp(input int v32, input int v16);
        exp_q.push_back(32'(v32));
        exp16_q.push_back(16'(v16));
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && out_ready) begin
            if (exp_q.size() == 0) fail("acc32 result with nothing expected");
            else check("acc32 result", $signed(bus.out_acc), $signed(exp_q.pop_front()));
        end
        if (bus16.out_valid && out_ready) begin
            if (exp16_q.size() == 0) fail("acc16 result with nothing expected");
            else check("acc16 result", $signed(bus16.out_acc), $signed(exp16_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        cfg_len = 16'(len);
        tick();
        start   = 1'b0;
    endtask

    // Presents a pair and returns just after the edge on which it was accepted.
    task automatic send(input int a, input int b);
        logic hs;
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 8'(b);
        for (int i = 0; i < 50; i++) begin
            hs = bus.in_ready;
            tick();
            if (hs) return;
        end
        fail("send: in_ready timeout");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid) return;
            tick();
        end
        fail("wait_valid: out_valid timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},      bus.busy,      0);
        check({tag, " in_ready"},  bus.in_ready,  0);
        check({tag, " out_valid"}, bus.out_valid, 0);
        check({tag, " out_acc"},   bus.out_acc,   0);
        check({tag, " out_acc16"}, bus16.out_acc, 0);
        check({tag, " state"},     st32,          IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        #1;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // 1: back-to-back pairs, latency of one cycle after the last handshake
        push_exp(-72, -72);
        do_start(4);
        send(1, 2);
        send(3, 4);
        send(-5, 6);
        check("t1 out_valid before last pair", bus.out_valid, 0);
        send(7, -8);
        in_valid = 1'b0;
        check("t1 out_valid after last pair", bus.out_valid, 1);
        check("t1 in_ready in DONE", bus.in_ready, 0);
        tick();
        tick();

        // 2: gaps in in_valid; 48387 wraps to -17149 in the 16-bit instance
        push_exp(48387, -17149);
        do_start(3);
        for (int k = 0; k < 3; k++) begin
            send(127, 127);
            in_valid = 1'b0;
            check("t2 busy", bus.busy, 1);
            if (k < 2) tick();
        end
        wait_valid();
        tick();
        tick();

        // 3: output back-pressure, then a start coincident with release is dropped
        push_exp(128, 128);
        out_ready = 1'b0;
        do_start(2);
        send(-128, -128);
        send(-128, 127);
        in_valid = 1'b0;
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3 stalled out_valid", bus.out_valid, 1);
            check("t3 stalled out_acc", $signed(bus.out_acc), 128);
            check("t3 stalled out_acc16", $signed(bus16.out_acc), 128);
        end
        tick();
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_len   = 16'd0;
        tick();
        start = 1'b0;
        check("t3 busy after release", bus.busy, 0);
        check("t3 out_valid after release", bus.out_valid, 0);
        check("t3 state after release", st32, IDLE);
        tick();
        check("t3 start in DONE ignored", bus.busy, 0);

        // 5: zero-length dot product
`ifdef MAC_BIAS_EN
        bias = 32'd1000;
        push_exp(1000, 1000);
`else
        push_exp(0, 0);
`endif
        do_start(0);
        check("t5 out_valid after start", bus.out_valid, 1);
        check("t5 in_ready", bus.in_ready, 0);
        check("t5 state", st16, DONE);
        tick();
        check("t5 in_ready after done", bus.in_ready, 0);
        check("t5 busy after done", bus.busy, 0);
`ifdef MAC_BIAS_EN
        bias = 32'd0;
`endif
        tick();

        // 6: reset mid-accumulation, then a clean run
        do_start(4);
        send(1, 1);
        send(2, 2);
        check("t6 in_ready before reset", bus.in_ready, 1);
        rst = 1'b1;
        #1;
        check_all_zero("t6 async reset");
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        push_exp(9, 9);
        do_start(1);
        send(3, 3);
        in_valid = 1'b0;
        wait_valid();
        tick();
        tick();
        tick();

        check("queue32 drained", exp_q.size(), 0);
        check("queue16 drained", exp16_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
